// File: rtl/bounded_counter_mon.sv
// bounded_counter_mon
//   Up/down counter with a programmable upper limit, saturate or wrap
//   behaviour at both ends, and a limit monitor that reports violations.
//
//   Optional assertions: define BOUNDED_COUNTER_MON_SVA_EN to compile
//   concurrent checks into the module. RTL behaviour is the same either way.
//
// Parameters
//   WIDTH        counter / limit width (2..32)
//   RESET_VAL    count after reset and after clr (must be <= RESET_LIMIT)
//   RESET_LIMIT  effective limit until limit_wr is first asserted
//
// Ports
//   clk, reset_n        clock (posedge) and async active-low reset
//   clr, load, load_val synchronous clear / load
//   en, up_dn, mode     count enable, direction (1=up), 0=saturate 1=wrap
//   limit_wr, limit_in  limit register write
//   err_clr             clears err_sticky
//   count, limit_q      current count and effective limit
//   at_limit, at_zero   boundary flags decoded from registers
//   ovf_pulse/unf_pulse one-cycle boundary event pulses
//   err_sticky          sticky limit-violation flag
module bounded_counter_mon #(
  parameter int WIDTH       = 8,
  parameter int RESET_VAL   = 0,
  parameter int RESET_LIMIT = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             limit_wr,
  input  logic [WIDTH-1:0] limit_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit_q,
  output logic             at_limit,
  output logic             at_zero,
  output logic             ovf_pulse,
  output logic             unf_pulse,
  output logic             err_sticky
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_LIM = WIDTH'(RESET_LIMIT);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             err_q, err_d;
  logic             err_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RST_VAL;
      limit_q <= RST_LIM;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    err_set = 1'b0;

    // Count above limit only happens right after the limit was lowered;
    // pulling it back takes precedence over everything else.
    if (count_q > limit_q) begin
      count_d = limit_q;
      err_set = 1'b1;
    end else if (clr) begin
      count_d = RST_VAL;
    end else if (load) begin
      if (load_val <= limit_q) begin
        count_d = load_val;
      end else begin
        count_d = limit_q;
        err_set = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (count_q < limit_q) begin
          count_d = count_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
          if (mode) count_d = '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          unf_d = 1'b1;
          // With limit_q == 0 this reloads 0, so wrap degenerates to saturate.
          if (mode) count_d = limit_q;
        end
      end
    end

    // Count update above already used the old limit; the new one takes
    // effect from the next cycle.
    limit_d = limit_wr ? limit_in : limit_q;

    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  assign count      = count_q;
  assign at_limit   = (count_q == limit_q);
  assign at_zero    = (count_q == '0);
  assign ovf_pulse  = ovf_q;
  assign unf_pulse  = unf_q;
  assign err_sticky = err_q;

`ifdef BOUNDED_COUNTER_MON_SVA_EN
  // Exempt the cycle after a limit write that lowered the limit.
  a_count_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    (count_q <= limit_q) ||
    ($past(limit_wr) && (limit_q < $past(limit_q))))
    else $error("bounded_counter_mon: count %0d above limit %0d", count_q, limit_q);

  a_pulse_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(ovf_q && unf_q))
    else $error("bounded_counter_mon: ovf_pulse and unf_pulse both high");

  a_err_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (err_q && !err_clr) |=> err_q)
    else $error("bounded_counter_mon: err_sticky dropped without err_clr");

  a_sat_step: assert property (@(posedge clk) disable iff (!reset_n)
    (!mode && !clr && !load && !limit_wr && (count_q <= limit_q)) |=>
      ((count_q == $past(count_q)) ||
       ({1'b0, count_q} == {1'b0, $past(count_q)} + 1'b1) ||
       ({1'b0, count_q} + 1'b1 == {1'b0, $past(count_q)})))
    else $error("bounded_counter_mon: saturate-mode step larger than 1");
`endif

endmodule

// File: tb/tb_bounded_counter_mon.sv
module tb_bounded_counter_mon;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters (WIDTH 8, limit 100)
  logic       reset_n, clr, load, en, up_dn, mode, limit_wr, err_clr;
  logic [7:0] load_val, limit_in;
  logic [7:0] count, limit_q;
  logic       at_limit, at_zero, ovf_pulse, unf_pulse, err_sticky;

  // Instance B: WIDTH 4, limit 15, wrap mode up-counting
  logic       b_reset_n, b_load, b_en;
  logic [3:0] b_load_val;
  logic [3:0] b_count, b_limit_q;
  logic       b_at_limit, b_at_zero, b_ovf, b_unf, b_err;

  int total = 0;
  int bad   = 0;

  bounded_counter_mon dut_a (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .mode(mode), .limit_wr(limit_wr), .limit_in(limit_in),
    .err_clr(err_clr), .count(count), .limit_q(limit_q), .at_limit(at_limit),
    .at_zero(at_zero), .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse),
    .err_sticky(err_sticky)
  );

  bounded_counter_mon #(.WIDTH(4), .RESET_VAL(0), .RESET_LIMIT(15)) dut_b (
    .clk(clk), .reset_n(b_reset_n), .clr(1'b0), .load(b_load), .load_val(b_load_val),
    .en(b_en), .up_dn(1'b1), .mode(1'b1), .limit_wr(1'b0), .limit_in(4'd0),
    .err_clr(1'b0), .count(b_count), .limit_q(b_limit_q), .at_limit(b_at_limit),
    .at_zero(b_at_zero), .ovf_pulse(b_ovf), .unf_pulse(b_unf), .err_sticky(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1; mode = 1'b0;
    limit_wr = 1'b0; err_clr = 1'b0; load_val = '0; limit_in = '0;
    b_reset_n = 1'b0; b_load = 1'b0; b_en = 1'b0; b_load_val = '0;

    step();
    check("rst_count",  count, 0);
    check("rst_limit",  limit_q, 100);
    check("rst_ovf",    ovf_pulse, 0);
    check("rst_unf",    unf_pulse, 0);
    check("rst_err",    err_sticky, 0);
    check("rst_atzero", at_zero, 1);
    check("rst_atlim",  at_limit, 0);
    reset_n = 1'b1;

    // Saturating up-count for 110 cycles
    en = 1'b1; up_dn = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 110; i++) begin
      step();
      check("sat_count", count, (i < 100) ? i : 100);
      check("sat_ovf",   ovf_pulse, (i >= 101) ? 1 : 0);
      check("sat_unf",   unf_pulse, 0);
    end
    check("sat_atlim", at_limit, 1);
    check("sat_err",   err_sticky, 0);

    // Wrap at top, then wrap at bottom
    mode = 1'b1;
    step();
    check("wrap_up_count", count, 0);
    check("wrap_up_ovf",   ovf_pulse, 1);
    up_dn = 1'b0;
    step();
    check("wrap_dn_count", count, 100);
    check("wrap_dn_unf",   unf_pulse, 1);
    check("wrap_dn_ovf",   ovf_pulse, 0);
    en = 1'b0;
    step();
    check("idle_count", count, 100);
    check("idle_ovf",   ovf_pulse, 0);
    check("idle_unf",   unf_pulse, 0);

    // Over-limit load, set-wins-over-clear, then clear
    load = 1'b1; load_val = 8'd150;
    step();
    check("ovl_count", count, 100);
    check("ovl_err",   err_sticky, 1);
    err_clr = 1'b1;
    step();
    check("set_wins_err", err_sticky, 1);
    load = 1'b0;
    step();
    check("errclr_err", err_sticky, 0);
    err_clr = 1'b0;

    // Lower limit below count: update with old limit, clamp next cycle
    load = 1'b1; load_val = 8'd80;
    step();
    check("ld80_count", count, 80);
    load = 1'b0;
    limit_wr = 1'b1; limit_in = 8'd50; en = 1'b1; up_dn = 1'b1; mode = 1'b0;
    step();
    check("lw_limit", limit_q, 50);
    check("lw_count", count, 81);
    limit_wr = 1'b0;
    step();
    check("clamp_count", count, 50);
    check("clamp_err",   err_sticky, 1);
    check("clamp_ovf",   ovf_pulse, 0);
    step();
    check("post_clamp_count", count, 50);
    check("post_clamp_ovf",   ovf_pulse, 1);

    // clr beats load
    en = 1'b0; clr = 1'b1; load = 1'b1; load_val = 8'd7;
    step();
    check("clr_ld_count", count, 0);
    clr = 1'b0; load = 1'b0;

    // Saturating down at zero
    en = 1'b1; up_dn = 1'b0; mode = 1'b0;
    step();
    check("satdn_count", count, 0);
    check("satdn_unf",   unf_pulse, 1);
    check("satdn_atzero", at_zero, 1);

    // Limit of zero: every enabled step is a boundary event
    en = 1'b0; limit_wr = 1'b1; limit_in = 8'd0;
    step();
    check("lim0_limit", limit_q, 0);
    limit_wr = 1'b0; en = 1'b1; up_dn = 1'b1; mode = 1'b1;
    step();
    check("lim0_up_count", count, 0);
    check("lim0_up_ovf",   ovf_pulse, 1);
    up_dn = 1'b0;
    step();
    check("lim0_dn_count", count, 0);
    check("lim0_dn_unf",   unf_pulse, 1);
    check("lim0_dn_ovf",   ovf_pulse, 0);

    // Async reset mid-operation restores the reset limit
    en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_a_limit", limit_q, 100);
    check("arst_a_unf",   unf_pulse, 0);
    reset_n = 1'b1;

    // Instance B: 4-bit wrap
    step();
    b_reset_n = 1'b1;
    b_load = 1'b1; b_load_val = 4'd14;
    step();
    check("b_ld14", b_count, 14);
    b_load = 1'b0; b_en = 1'b1;
    step();
    check("b_15",     b_count, 15);
    check("b_15_ovf", b_ovf, 0);
    step();
    check("b_wrap",     b_count, 0);
    check("b_wrap_ovf", b_ovf, 1);
    step();
    step();
    check("b_2", b_count, 2);
    #2 b_reset_n = 1'b0;
    #1;
    check("b_arst_count", b_count, 0);
    check("b_arst_limit", b_limit_q, 15);
    b_reset_n = 1'b1;
    b_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
